// File: rtl/host_wr_buffer_pkg.sv
// Shared types for the host write buffer: drain FSM states, line entry layout
// and a helper that places one 32-bit word into an otherwise zero line.
package host_wr_buffer_pkg;

  localparam int LINE_WORDS = 16;
  localparam int LINE_BITS  = 512;
  localparam int TAG_W      = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STROBE = 2'd2,
    POP    = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      line_addr;
    logic [LINE_BITS-1:0]  data;
    logic [LINE_WORDS-1:0] mask;
  } line_entry_t;

  function automatic logic [LINE_BITS-1:0] place_word(input logic [3:0] w, input logic [31:0] d);
    place_word = '0;
    place_word[{w, 5'b00000} +: 32] = d;
  endfunction

endpackage

// File: rtl/host_wr_buffer_cam.sv
// DEPTH-way line-address compare; one hit bit per valid entry holding the key line.
module wb_line_cam
  import host_wr_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            key,
  output logic [DEPTH-1:0]            hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid[i] && (tags[i] == key);
    end
  end

endmodule

// File: rtl/host_wr_buffer.sv
// Coalescing write buffer: packs 32-bit stores into 512-bit lines held in a
// circular FIFO and drains the head line to the host with a wgo/ready/we handshake.
module host_wr_buffer
  import host_wr_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_trd,
  output logic              st_stall,
  input  logic [31:0]       chk_addr,
  output logic              chk_hit,
  input  logic              flush,
  output logic              idle,
  input  logic              host_wr_ready,
  output logic              host_wgo,
  output logic              host_we,
  output logic [63:0]       cpu_addr,
  output logic [LINE_W-1:0] host_data_bus_write_out,
  output logic [15:0]       host_wr_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  line_entry_t entries [DEPTH];
  line_entry_t head_e;
  line_entry_t new_entry;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_m1;
  logic [CNT_W-1:0] count;
  wb_state_t        state;

  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][TAG_W-1:0] ent_tag;
  logic [DEPTH-1:0]            chk_vec;
  logic [DEPTH-1:0]            st_vec;

  logic [3:0] w;
  logic [8:0] word_lsb;
  logic       draining;
  logic       full;
  logic       coalesce;
  logic       allocate;
  logic       st_fire;
  logic       alloc_fire;
  logic       do_pop;
  logic       show_head;
  logic       unused_bits;

  // Thread id and sub-word address bits carry no function here.
  assign unused_bits = ^{st_trd, st_addr[1:0], chk_addr[5:0]};

  always_comb begin
    ent_valid = '0;
    ent_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries[i].valid;
      ent_tag[i]   = entries[i].line_addr;
    end
  end

  wb_line_cam #(.DEPTH(DEPTH)) u_chk_cam (
    .valid (ent_valid),
    .tags  (ent_tag),
    .key   (chk_addr[31:6]),
    .hit   (chk_vec)
  );

  wb_line_cam #(.DEPTH(DEPTH)) u_st_cam (
    .valid (ent_valid),
    .tags  (ent_tag),
    .key   (st_addr[31:6]),
    .hit   (st_vec)
  );

  assign w        = st_addr[5:2];
  assign word_lsb = {w, 5'b00000};
  assign tail_m1  = tail - PTR_W'(1);
  assign draining = (state != IDLE);
  assign full     = (count == CNT_W'(DEPTH));

  // The head is frozen from the cycle the FSM leaves IDLE until it is popped.
  assign coalesce   = !flush && st_vec[tail_m1] && !(draining && (tail_m1 == head));
  assign allocate   = !coalesce && !full;
  assign st_stall   = st_valid && !coalesce && !allocate;
  assign st_fire    = st_valid && !st_stall;
  assign alloc_fire = st_fire && allocate;
  assign do_pop     = (state == POP);

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.line_addr = st_addr[31:6];
    new_entry.data      = place_word(w, st_data);
    new_entry.mask      = 16'd1 << w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (st_fire && coalesce) begin
        entries[tail_m1].data[word_lsb +: 32] <= st_data;
        entries[tail_m1].mask[w]              <= 1'b1;
      end
      if (alloc_fire) begin
        entries[tail] <= new_entry;
        tail          <= tail + PTR_W'(1);
      end
      if (do_pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      case ({alloc_fire, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      host_wgo <= 1'b0;
      host_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state    <= REQ;
            host_wgo <= 1'b1;
          end
        end
        REQ: begin
          if (host_wr_ready) begin
            state    <= STROBE;
            host_wgo <= 1'b0;
            host_we  <= 1'b1;
          end
        end
        STROBE: begin
          state   <= POP;
          host_we <= 1'b0;
        end
        POP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign head_e    = entries[head];
  assign show_head = (state == REQ) || (state == STROBE);

  assign cpu_addr                = show_head ? {32'h0, head_e.line_addr, 6'b0} : 64'h0;
  assign host_data_bus_write_out = show_head ? head_e.data : '0;
  assign host_wr_mask            = show_head ? head_e.mask : 16'h0;
  assign chk_hit                 = |chk_vec;
  assign idle                    = (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_host_wr_buffer.sv
// Bench for host_wr_buffer: directed scenarios plus a randomized run checked
// against a word-addressed memory image built from accepted stores.
module tb_host_wr_buffer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_valid;
  logic [31:0]  st_addr;
  logic [31:0]  st_data;
  logic [2:0]   st_trd;
  logic         st_stall;
  logic [31:0]  chk_addr;
  logic         chk_hit;
  logic         flush;
  logic         idle;
  logic         host_wr_ready;
  logic         host_wgo;
  logic         host_we;
  logic [63:0]  cpu_addr;
  logic [511:0] host_data_bus_write_out;
  logic [15:0]  host_wr_mask;

  host_wr_buffer #(.DEPTH(DEPTH), .LINE_W(512)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .st_valid                (st_valid),
    .st_addr                 (st_addr),
    .st_data                 (st_data),
    .st_trd                  (st_trd),
    .st_stall                (st_stall),
    .chk_addr                (chk_addr),
    .chk_hit                 (chk_hit),
    .flush                   (flush),
    .idle                    (idle),
    .host_wr_ready           (host_wr_ready),
    .host_wgo                (host_wgo),
    .host_we                 (host_we),
    .cpu_addr                (cpu_addr),
    .host_data_bus_write_out (host_data_bus_write_out),
    .host_wr_mask            (host_wr_mask)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] data;
    logic [15:0]  mask;
  } wr_t;

  wr_t         we_q[$];
  wr_t         mon_r;
  logic [31:0] host_mem [int];
  logic        prev_we = 1'b0;

  // Host side: records every write strobe and applies it to a host memory image.
  always @(negedge clk) begin
    if (rst_n && host_we) begin
      checks++;
      if (prev_we !== 1'b0 || host_wgo !== 1'b0) begin
        errors++;
        $display("FAIL we_pulse: prev_we=%b host_wgo=%b, required 0 and 0", prev_we, host_wgo);
      end
      mon_r.addr = cpu_addr;
      mon_r.data = host_data_bus_write_out;
      mon_r.mask = host_wr_mask;
      we_q.push_back(mon_r);
      for (int i = 0; i < 16; i++) begin
        if (host_wr_mask[i]) host_mem[int'({cpu_addr[31:6], 4'(i)})] = host_data_bus_write_out[32*i +: 32];
      end
    end
    prev_we = host_we;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    st_valid      = 1'b0;
    st_addr       = '0;
    st_data       = '0;
    st_trd        = '0;
    chk_addr      = '0;
    flush         = 1'b0;
    host_wr_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    we_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({st_stall, chk_hit, idle, host_wgo, host_we} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_flags: stall/hit/idle/wgo/we=%b, required 00100",
               {st_stall, chk_hit, idle, host_wgo, host_we});
    end
    checks++;
    if (cpu_addr !== 64'h0 || host_wr_mask !== 16'h0 || host_data_bus_write_out !== 512'h0) begin
      errors++;
      $display("FAIL reset_bus: cpu_addr=%h mask=%h, required zero address, mask and data", cpu_addr, host_wr_mask);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (idle !== 1'b1 || host_wgo !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: idle=%b wgo=%b, required 1/0", idle, host_wgo);
    end
  endtask

  task automatic test_coalesce();
    int seen;
    do_reset();
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hAAAA; st_trd = 3'($urandom_range(0, 7));
    #1;
    checks++;
    if (st_stall !== 1'b0) begin errors++; $display("FAIL coal_st0_stall: got %b required 0", st_stall); end
    tick();
    st_addr = 32'h104; st_data = 32'hBBBB;
    #1;
    checks++;
    if (st_stall !== 1'b0) begin errors++; $display("FAIL coal_st1_stall: got %b required 0", st_stall); end
    tick();
    st_valid = 1'b0;
    chk_addr = 32'h13C;
    #1;
    checks++;
    if (host_wgo !== 1'b1 || cpu_addr !== 64'h100 || host_wr_mask !== 16'h0003) begin
      errors++;
      $display("FAIL coal_head: wgo=%b addr=%h mask=%h, required 1/100/0003", host_wgo, cpu_addr, host_wr_mask);
    end
    checks++;
    if (chk_hit !== 1'b1) begin errors++; $display("FAIL chk_hit_pending: got %b required 1", chk_hit); end
    chk_addr = 32'h140;
    #1;
    checks++;
    if (chk_hit !== 1'b0) begin errors++; $display("FAIL chk_miss: got %b required 0", chk_hit); end
    chk_addr = 32'h13C;
    host_wr_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (host_we) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL coal_we_timeout: host_we not seen, required within 8 cycles"); end
    checks++;
    if (host_data_bus_write_out[31:0] !== 32'hAAAA || host_data_bus_write_out[63:32] !== 32'hBBBB) begin
      errors++;
      $display("FAIL coal_bus: w0=%h w1=%h, required AAAA/BBBB",
               host_data_bus_write_out[31:0], host_data_bus_write_out[63:32]);
    end
    tick();
    checks++;
    if (host_we !== 1'b0 || idle !== 1'b0 || chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL coal_pop_cycle: we=%b idle=%b hit=%b, required 0/0/1", host_we, idle, chk_hit);
    end
    tick();
    checks++;
    if (idle !== 1'b1 || chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL coal_after_pop: idle=%b hit=%b, required 1/0", idle, chk_hit);
    end
    host_wr_ready = 1'b0;
  endtask

  task automatic test_full_stall();
    logic [31:0] exp_q[$];
    logic [31:0] exp_d[$];
    logic [3:0]  wi;
    int          ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wi = 4'($urandom_range(0, 15));
      st_valid = 1'b1;
      st_addr  = 32'(i * 64) + {26'd0, wi, 2'b00};
      st_data  = $urandom;
      exp_q.push_back(st_addr);
      exp_d.push_back(st_data);
      #1;
      if (i < 4) begin
        checks++;
        if (st_stall !== 1'b0) begin errors++; $display("FAIL full_fill%0d: stall=%b required 0", i, st_stall); end
        tick();
      end
    end
    checks++;
    if (st_stall !== 1'b1) begin errors++; $display("FAIL full_stall: stall=%b required 1", st_stall); end
    repeat (3) tick();
    checks++;
    if (st_stall !== 1'b1) begin errors++; $display("FAIL full_stall_hold: stall=%b required 1", st_stall); end
    host_wr_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (!st_stall) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (ok != 1 || we_q.size() < 1) begin
      errors++;
      $display("FAIL full_accept: released=%0d host_writes=%0d, required 1 and >=1", ok, we_q.size());
    end
    tick();
    st_valid = 1'b0;
    for (int k = 0; k < 60 && we_q.size() < 5; k++) tick();
    checks++;
    if (we_q.size() != 5) begin errors++; $display("FAIL full_count: writes=%0d required 5", we_q.size()); end
    for (int i = 0; i < 5 && i < we_q.size(); i++) begin
      wi = exp_q[i][5:2];
      checks++;
      if (we_q[i].addr !== {32'h0, exp_q[i][31:6], 6'b0} || we_q[i].mask !== (16'd1 << wi) ||
          we_q[i].data[32*wi +: 32] !== exp_d[i]) begin
        errors++;
        $display("FAIL full_order%0d: addr=%h mask=%h word=%h, required addr=%h mask=%h word=%h", i,
                 we_q[i].addr, we_q[i].mask, we_q[i].data[32*wi +: 32],
                 {32'h0, exp_q[i][31:6], 6'b0}, 16'd1 << wi, exp_d[i]);
      end
    end
    host_wr_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    flush    = 1'b1;
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h1111_0000;
    tick();
    st_addr = 32'h204; st_data = 32'h2222_0000;
    tick();
    st_valid = 1'b0;
    #1;
    checks++;
    if (host_wgo !== 1'b1 || cpu_addr !== 64'h200 || host_wr_mask !== 16'h0001) begin
      errors++;
      $display("FAIL flush_head: wgo=%b addr=%h mask=%h, required 1/200/0001", host_wgo, cpu_addr, host_wr_mask);
    end
    host_wr_ready = 1'b1;
    for (int k = 0; k < 30 && we_q.size() < 2; k++) tick();
    checks++;
    if (we_q.size() != 2) begin
      errors++;
      $display("FAIL flush_count: writes=%0d required 2", we_q.size());
    end else begin
      checks++;
      if (we_q[0].mask !== 16'h0001 || we_q[1].mask !== 16'h0002 ||
          we_q[0].data[31:0] !== 32'h1111_0000 || we_q[1].data[63:32] !== 32'h2222_0000) begin
        errors++;
        $display("FAIL flush_masks: masks=%h/%h, required 0001/0002 with matching words",
                 we_q[0].mask, we_q[1].mask);
      end
    end
    for (int k = 0; k < 10 && !idle; k++) tick();
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle: idle=%b required 1", idle); end
    flush = 1'b0;
    host_wr_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int n;
    int stray;
    do_reset();
    st_valid = 1'b1; st_addr = 32'h300; st_data = $urandom;
    tick();
    st_valid = 1'b0;
    tick();
    checks++;
    if (host_wgo !== 1'b1) begin errors++; $display("FAIL mid_req: wgo=%b required 1", host_wgo); end
    host_wr_ready = 1'b1;
    tick();
    checks++;
    if (host_we !== 1'b1) begin errors++; $display("FAIL mid_strobe: we=%b required 1", host_we); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (host_we !== 1'b0 || host_wgo !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: we=%b wgo=%b idle=%b, required 0/0/1", host_we, host_wgo, idle);
    end
    rst_n = 1'b1;
    n = we_q.size();
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (host_we || host_wgo) stray++;
    end
    checks++;
    if (stray != 0 || we_q.size() != n || idle !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: stray=%0d writes_added=%0d idle=%b, required 0/0/1", stray, we_q.size() - n, idle);
    end
    host_wr_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] model_mem [int];
    int          accepted;
    int          shown;
    logic        hold;
    do_reset();
    host_mem.delete();
    accepted = 0;
    hold     = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!hold) begin
        st_valid = 1'($urandom_range(0, 1));
        st_addr  = 32'h1000 + 32'($urandom_range(0, 5) * 64) + 32'($urandom_range(0, 15) * 4)
                   + 32'($urandom_range(0, 3));
        st_data  = $urandom;
        st_trd   = 3'($urandom_range(0, 7));
      end
      host_wr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) flush = ~flush;
      chk_addr = 32'h1000 + 32'($urandom_range(0, 511));
      #1;
      if (st_valid && !st_stall) begin
        model_mem[int'(st_addr[31:2])] = st_data;
        accepted++;
      end
      hold = st_valid && st_stall;
      tick();
    end
    st_valid      = 1'b0;
    flush         = 1'b0;
    host_wr_ready = 1'b1;
    for (int k = 0; k < 200 && !idle; k++) tick();
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL rand_drain: idle=%b required 1", idle); end
    checks++;
    if (we_q.size() > accepted || host_mem.num() != model_mem.num()) begin
      errors++;
      $display("FAIL rand_counts: writes=%0d accepted=%0d host_words=%0d model_words=%0d",
               we_q.size(), accepted, host_mem.num(), model_mem.num());
    end
    shown = 0;
    foreach (model_mem[k]) begin
      checks++;
      if (!host_mem.exists(k) || host_mem[k] !== model_mem[k]) begin
        errors++;
        if (shown < 10) begin
          $display("FAIL rand_word: word_addr=%h host=%h required %h", k,
                   host_mem.exists(k) ? host_mem[k] : 32'hx, model_mem[k]);
        end
        shown++;
      end
    end
    host_wr_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_coalesce();
    test_full_stall();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
